// File: rtl/mux_4_1_rr_sched_if.sv
// Requester-side bus of the round-robin 4:1 mux scheduler: request/data lines in,
// registered grant, select and muxed data bit out.
interface mux_4_1_rr_sched_if;
    logic [3:0] req;
    logic [3:0] data;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       Y;
    logic       y_valid;
    logic       busy;

    modport master (
        output req, data,
        input  gnt, sel, Y, y_valid, busy
    );

    modport slave (
        input  req, data,
        output gnt, sel, Y, y_valid, busy
    );
endinterface

// File: rtl/mux_4_1_rr_sched.sv
// Round-robin scheduler driving the select of a shared 4:1 single-bit mux, with a registered
// mux output. Define MUX_SCHED_TIMEOUT_EN to add a HOLD_MAX-cycle forced handover.
module mux_4_1_rr_sched #(
    parameter int HOLD_MAX = 8
) (
    input logic               clk,
    input logic               rst_n,
    mux_4_1_rr_sched_if.slave bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic       y_q, y_d;
    logic       yv_q, yv_d;
    logic [2:0] pick;
    logic       hand;

`ifdef MUX_SCHED_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] others;
`endif

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
        $error("HOLD_MAX must be within 1..255");
    end

    // Returns {found, index} of the first set request at or after 'start', wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'b00;
            sel_q   <= 2'b00;
            gnt_q   <= 4'b0000;
            y_q     <= 1'b0;
            yv_q    <= 1'b0;
`ifdef MUX_SCHED_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
`ifdef MUX_SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // A handover searches from the slot after the releasing owner, so the releaser ranks last.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        y_d     = y_q;
        yv_d    = yv_q;
        pick    = 3'b000;
        hand    = 1'b0;
`ifdef MUX_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        others  = bus.req & ~(4'b0001 << sel_q);
`endif
        case (state_q)
            IDLE: begin
                yv_d = 1'b0;
                pick = rr_pick(bus.req, ptr_q);
                if (pick[2]) begin
                    state_d = GRANT;
                    sel_d   = pick[1:0];
                    gnt_d   = 4'b0001 << pick[1:0];
`ifdef MUX_SCHED_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            GRANT: begin
                hand = !bus.req[sel_q];
`ifdef MUX_SCHED_TIMEOUT_EN
                if (cnt_q == HOLD_MAX_C && others != 4'b0000) hand = 1'b1;
`endif
                if (hand) begin
                    ptr_d = sel_q + 2'd1;
                    yv_d  = 1'b0;
                    pick  = rr_pick(bus.req, sel_q + 2'd1);
`ifdef MUX_SCHED_TIMEOUT_EN
                    cnt_d = 8'd0;
`endif
                    if (pick[2] && pick[1:0] != sel_q) begin
                        sel_d = pick[1:0];
                        gnt_d = 4'b0001 << pick[1:0];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else begin
                    y_d  = bus.data[sel_q];
                    yv_d = 1'b1;
`ifdef MUX_SCHED_TIMEOUT_EN
                    if (cnt_q != HOLD_MAX_C) cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.Y       = y_q;
    assign bus.y_valid = yv_q;
    assign bus.busy    = (state_q == GRANT);

endmodule

// File: doc/mux_4_1_rr_sched.md
Name: mux_4_1_rr_sched

Overview:
Round-robin scheduler that shares one 4:1 single-bit mux between four requesters. It arbitrates the request lines and drives the mux select. It also registers the selected data bit and flags when that bit is valid. It sits in front of the 4:1 mux datapath, so the select is never driven directly by requesters.

Parameters:
HOLD_MAX, 8, maximum grant tenure in cycles while another requester is pending; used only when the optional feature is compiled in; legal range 1..255.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
req  input  4  request per requester; req[i] is held high for the whole tenure.
data  input  4  data bit per requester; data[i] belongs to requester i.
gnt  output  4  one-hot grant, registered; all zero when idle.
sel  output  2  mux select, registered; equals the index of the granted requester.
Y  output  1  registered mux output, data[sel].
y_valid  output  1  high when Y holds a bit sampled under a grant.
busy  output  1  high in state GRANT.

Behaviour:
- Reset (async, rst_n low), applied immediately regardless of state:
  - gnt=0, sel=2'b00, Y=0, y_valid=0, busy=0.
  - Priority pointer ptr=0, state IDLE, hold counter=0.
- Priority search: starting at index ptr and going upward mod 4, pick the first i with req[i]=1.
- IDLE:
  - If req==0, stay in IDLE and hold all outputs. y_valid=0.
  - Else, at the next edge: gnt=onehot(winner), sel=winner, state GRANT, counter=0.
  - Latency: req asserted before edge N produces a grant after edge N.
- GRANT, each edge:
  - Y<=data[sel], y_valid<=1. Y lags data by one cycle.
  - The first valid Y appears one edge after gnt asserts.
- Release: req[sel]=0 at an edge.
  - If any other req is set: hand over in that same edge, with zero bubble. ptr<=sel+1 mod 4, then search from the new ptr. gnt and sel switch and state stays GRANT.
  - If no other req is set: gnt=0 and state IDLE. ptr<=sel+1 mod 4. sel holds its value.
  - In both cases, at this edge y_valid<=0 and Y holds. This covers the bit from the releasing requester's last cycle.
- Re-request in the same cycle as release: the releasing index is lowest priority, so another pending requester wins. If it is the only requester, it is re-granted after one IDLE cycle.
- Pointer wrap: ptr=3 with release moves to 0.
- Simultaneous requests from IDLE after reset (ptr=0) with req=4'b1010: requester 1 wins. On its release, requester 3 wins.
- gnt is always one-hot or zero. Y and y_valid are never driven combinationally from req.
- Changing data while not granted has no effect on Y.

Optional Feature:
Macro MUX_SCHED_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit hold counter increments each GRANT cycle and saturates at HOLD_MAX.
  - When the counter equals HOLD_MAX and any other req is set, a forced handover occurs at the next edge, exactly as in Release, even though req[sel] is still high. The counter then resets to 0.
  - With no other requester pending, the grant is held indefinitely and the counter stays saturated.
- Without the macro: no counter logic is present, HOLD_MAX is ignored, and a grant is held until req[sel] drops.

Test Plan:
1. Reset mid-grant: requester 2 granted with data=4'b0100, assert rst_n=0 between edges -> gnt=0, sel=0, Y=0, y_valid=0, busy=0 immediately, without waiting for a clock; after release, req=4'b0001 -> gnt=4'b0001 after 1 edge.
2. Single requester: req=4'b0100, data=4'b0100 -> gnt=4'b0100, sel=2'b10 after 1 edge; Y=1, y_valid=1 after 2 edges. Drop req -> gnt=0, busy=0, y_valid=0 next edge.
3. Round robin: from reset hold req=4'b1111, each granted requester drops req for one cycle after 3 tenure cycles -> grant order 0,1,2,3,0 with zero-bubble handovers.
4. Data sweep: for each grant i in 0..3, step data through 0..15, one per cycle -> Y equals data[i] of the previous cycle for all 16 values.
5. Simultaneous: req=4'b1010 from reset -> gnt=4'b0010. Release -> gnt=4'b1000 in the same edge. Release -> idle, with ptr then at 0.
6. With MUX_SCHED_TIMEOUT_EN and HOLD_MAX=8: req0 held high, req2 raised at cycle 3 of the grant -> grant moves to requester 2 at the edge after counter=8. With req0 alone, the grant is held for 50+ cycles.
